// File: rtl/paddle_pkg.sv
// -----------------------------------------------------------------------------
// paddle_pkg
// Shared definitions for the Arkanoid paddle controller: game run-state
// encodings, paddle direction codes and the ASCII key codes delivered by the
// keyboard receiver.
// -----------------------------------------------------------------------------
package paddle_pkg;

   // Run state as seen by the ball and video stages.
   typedef enum logic [1:0] {
      ST_READY  = 2'b00,
      ST_PLAY   = 2'b01,
      ST_PAUSED = 2'b10
   } game_state_t;

   // Direction requested by the currently held key.
   typedef enum logic [1:0] {
      DIR_NONE  = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_RIGHT = 2'b10
   } dir_t;

   localparam logic [7:0] KEY_LEFT   = 8'h41;  // 'A'
   localparam logic [7:0] KEY_RIGHT  = 8'h44;  // 'D'
   localparam logic [7:0] KEY_LAUNCH = 8'h57;  // 'W'
   localparam logic [7:0] KEY_PAUSE  = 8'h50;  // 'P'

endpackage

// File: rtl/paddle_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider 0..DIV-1 producing a one-cycle tick while the count
// sits at DIV-1. The tick is registered: it is set on the edge that moves the
// count onto DIV-1, so it coincides exactly with that count value.
// Ports:
//   clk  in  1  system clock
//   rst  in  1  asynchronous reset, active-low
//   tick out 1  one-cycle pulse every DIV clocks
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int unsigned DIV = 250000   // must be >= 2
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

   logic [CW-1:0] cnt_r;

   // Divider count and the registered tick that accompanies the last count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {CW{1'b0}};
         tick  <= 1'b0;
      end else begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
         tick <= (cnt_r == CNT_PRE);
      end
   end

endmodule

// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
// Turns decoded keyboard input into the paddle X position, a one-cycle ball
// launch pulse and the READY/PLAY/PAUSED run state.
// Ports:
//   clk        in  1   system clock
//   rst        in  1   asynchronous reset, active-low
//   ps2_byte   in  8   ASCII code of last key, valid while ps2_state=1
//   ps2_state  in  1   1 while a key is held
//   ball_lost  in  1   one-cycle pulse: ball fell out
//   paddle_x   out 10  left edge of paddle, 0..SCREEN_W-PADDLE_W
//   launch     out 1   one-cycle pulse releasing the ball
//   game_state out 2   00 READY, 01 PLAY, 10 PAUSED
//   paused     out 1   game_state == PAUSED
// -----------------------------------------------------------------------------
module paddle_ctrl
   import paddle_pkg::*;
#(
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned PADDLE_W    = 80,
   parameter int unsigned STEP        = 4,
   parameter int unsigned TICK_DIV    = 250000,
   parameter int unsigned ACCEL_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ps2_byte,
   input  logic       ps2_state,
   input  logic       ball_lost,
   output logic [9:0] paddle_x,
   output logic       launch,
   output logic [1:0] game_state,
   output logic       paused
);

   localparam logic [9:0] XMAX_V  = 10'(SCREEN_W - PADDLE_W);
   localparam logic [9:0] X_RESET = 10'((SCREEN_W - PADDLE_W) / 2);
   localparam logic [9:0] STEP_1  = 10'(STEP);
   localparam logic [9:0] STEP_2  = 10'(2 * STEP);
   localparam int unsigned HW     = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;
   localparam logic [HW-1:0] ACCEL_V = HW'(ACCEL_TICKS);

   logic              tick_s;
   logic              ps2_state_d_r;
   logic              press_s;
   dir_t              dir_s;
   dir_t              last_dir_r;
   logic              can_move_s;
   logic [HW-1:0]     hold_cnt_r;
   logic [HW-1:0]     eff_hold_s;
   logic [HW-1:0]     hold_inc_s;
   logic [9:0]        step_s;
   logic [10:0]       sum_s;
   logic [9:0]        next_x_s;
   logic [9:0]        x_r;
   game_state_t       state_r;
   logic              launch_r;
   logic              paused_r;

   tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Rising edge of the key-held flag; repeats while held never re-trigger.
   assign press_s = ps2_state & ~ps2_state_d_r;

   // Decode the held key into a movement direction.
   always_comb begin
      dir_s = DIR_NONE;
      if (ps2_state) begin
         case (ps2_byte)
            KEY_LEFT:  dir_s = DIR_LEFT;
            KEY_RIGHT: dir_s = DIR_RIGHT;
            default:   dir_s = DIR_NONE;
         endcase
      end else begin
         dir_s = DIR_NONE;
      end
   end

   // Step size and next position; a direction change restarts at base speed
   // even when the byte switches on the very cycle of a tick.
   always_comb begin
      can_move_s = (state_r != ST_PAUSED) && (dir_s != DIR_NONE);
      eff_hold_s = (dir_s == last_dir_r) ? hold_cnt_r : {HW{1'b0}};
      step_s     = (eff_hold_s >= ACCEL_V) ? STEP_2 : STEP_1;
      hold_inc_s = (eff_hold_s >= ACCEL_V) ? ACCEL_V : (eff_hold_s + HW'(1));
      sum_s      = {1'b0, x_r} + {1'b0, step_s};
      next_x_s   = x_r;
      case (dir_s)
         DIR_LEFT: begin
            if (x_r < step_s) begin
               next_x_s = 10'd0;
            end else begin
               next_x_s = x_r - step_s;
            end
         end
         DIR_RIGHT: begin
            if (sum_s > {1'b0, XMAX_V}) begin
               next_x_s = XMAX_V;
            end else begin
               next_x_s = sum_s[9:0];
            end
         end
         default: next_x_s = x_r;
      endcase
   end

   // Paddle position, acceleration hold counter and key-edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_r           <= X_RESET;
         hold_cnt_r    <= {HW{1'b0}};
         last_dir_r    <= DIR_NONE;
         ps2_state_d_r <= 1'b0;
      end else begin
         ps2_state_d_r <= ps2_state;
         if (can_move_s) begin
            last_dir_r <= dir_s;
            if (tick_s) begin
               x_r        <= next_x_s;
               hold_cnt_r <= hold_inc_s;
            end else begin
               hold_cnt_r <= eff_hold_s;
            end
         end else begin
            last_dir_r <= DIR_NONE;
            hold_cnt_r <= {HW{1'b0}};
         end
      end
   end

   // Run-state machine; ball_lost overrides any key press in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_READY;
         launch_r <= 1'b0;
         paused_r <= 1'b0;
      end else begin
         launch_r <= 1'b0;
         if (ball_lost) begin
            state_r  <= ST_READY;
            paused_r <= 1'b0;
         end else begin
            case (state_r)
               ST_READY: begin
                  if (press_s && (ps2_byte == KEY_LAUNCH)) begin
                     launch_r <= 1'b1;
                     state_r  <= ST_PLAY;
                  end
                  paused_r <= 1'b0;
               end
               ST_PLAY: begin
                  if (press_s && (ps2_byte == KEY_PAUSE)) begin
                     state_r  <= ST_PAUSED;
                     paused_r <= 1'b1;
                  end else begin
                     paused_r <= 1'b0;
                  end
               end
               ST_PAUSED: begin
                  if (press_s && (ps2_byte == KEY_PAUSE)) begin
                     state_r  <= ST_PLAY;
                     paused_r <= 1'b0;
                  end else begin
                     paused_r <= 1'b1;
                  end
               end
               default: begin
                  state_r  <= ST_READY;
                  paused_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign paddle_x   = x_r;
   assign launch     = launch_r;
   assign game_state = state_r;
   assign paused     = paused_r;

endmodule

// File: tb/tb_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_ctrl
// Directed bench for paddle_ctrl with a 4-cycle move tick and acceleration
// after 3 held ticks. Inputs change 1 time unit after a rising edge and
// outputs are sampled there too; any 4 consecutive edges contain one tick.
// -----------------------------------------------------------------------------
module tb_paddle_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] ps2_byte;
   logic       ps2_state;
   logic       ball_lost;
   logic [9:0] paddle_x;
   logic       launch;
   logic [1:0] game_state;
   logic       paused;

   int compared;
   int mismatched;

   paddle_ctrl #(
      .SCREEN_W    (640),
      .PADDLE_W    (80),
      .STEP        (4),
      .TICK_DIV    (4),
      .ACCEL_TICKS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_byte   (ps2_byte),
      .ps2_state  (ps2_state),
      .ball_lost  (ball_lost),
      .paddle_x   (paddle_x),
      .launch     (launch),
      .game_state (game_state),
      .paused     (paused)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [7:0] b, input logic held);
      ps2_byte  = b;
      ps2_state = held;
   endtask

   // Reference paddle model for long held runs
   int mx;
   int mh;
   task automatic model_move(input bit right);
      int st;
      st = (mh >= 3) ? 8 : 4;
      if (right) mx = (mx + st > 560) ? 560 : mx + st;
      else       mx = (mx < st) ? 0 : mx - st;
      mh = (mh >= 3) ? 3 : mh + 1;
   endtask

   initial begin
      int exp_a[6];
      logic seen;
      compared   = 0;
      mismatched = 0;
      rst = 1'b0;
      ps2_byte = 8'h00; ps2_state = 1'b0; ball_lost = 1'b0;
      exp_a = '{276, 272, 268, 260, 252, 244};

      cyc(3);
      rst = 1'b1;
      cyc(1);
      check("reset_x", 32'(paddle_x), 32'd280);
      check("reset_state", 32'(game_state), 32'd0);
      check("reset_launch", 32'(launch), 32'd0);
      check("reset_paused", 32'(paused), 32'd0);

      // Hold 'A' six ticks: 4,4,4 then accelerated 8,8,8
      key(8'h41, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(4);
         check($sformatf("left_tick%0d", i), 32'(paddle_x), 32'(exp_a[i]));
      end
      key(8'h41, 1'b0);
      cyc(8);
      check("left_release_hold", 32'(paddle_x), 32'd244);

      // Hold 'D' 100 ticks: saturates at 560
      mx = 244; mh = 0;
      key(8'h44, 1'b1);
      for (int i = 0; i < 100; i++) begin
         cyc(4);
         model_move(1'b1);
         check($sformatf("right_tick%0d", i), 32'(paddle_x), 32'(mx));
      end
      check("right_saturated", 32'(paddle_x), 32'd560);
      key(8'h44, 1'b0);
      cyc(2);

      // 'W' in READY: single launch pulse, then PLAY
      key(8'h57, 1'b1);
      cyc(1);
      check("launch_pulse", 32'(launch), 32'd1);
      check("launch_state", 32'(game_state), 32'd1);
      cyc(1);
      check("launch_one_clk", 32'(launch), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         seen = seen | launch;
      end
      check("w_held_no_repeat", 32'(seen), 32'd0);
      key(8'h57, 1'b0);
      cyc(2);
      key(8'h57, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         seen = seen | launch;
      end
      check("w_in_play_no_pulse", 32'(seen), 32'd0);
      check("w_in_play_state", 32'(game_state), 32'd1);
      key(8'h57, 1'b0);
      cyc(2);

      // Move left in PLAY to get off the right limit
      key(8'h41, 1'b1);
      cyc(4);
      check("play_left1", 32'(paddle_x), 32'd556);
      cyc(4);
      check("play_left2", 32'(paddle_x), 32'd552);
      key(8'h41, 1'b0);
      cyc(2);

      // Pause: no movement while 'D' held
      key(8'h50, 1'b1);
      cyc(1);
      check("pause_state", 32'(game_state), 32'd2);
      check("pause_flag", 32'(paused), 32'd1);
      key(8'h50, 1'b0);
      cyc(1);
      key(8'h44, 1'b1);
      cyc(20);
      check("paused_no_move", 32'(paddle_x), 32'd552);
      check("paused_still", 32'(game_state), 32'd2);
      key(8'h44, 1'b0);
      cyc(1);
      key(8'h50, 1'b1);
      cyc(1);
      check("unpause_state", 32'(game_state), 32'd1);
      check("unpause_flag", 32'(paused), 32'd0);
      key(8'h50, 1'b0);
      cyc(1);
      key(8'h44, 1'b1);
      cyc(4);
      check("after_unpause_base_step", 32'(paddle_x), 32'd556);
      key(8'h44, 1'b0);
      cyc(1);

      // ball_lost beats 'P' in PLAY
      key(8'h50, 1'b1);
      ball_lost = 1'b1;
      cyc(1);
      ball_lost = 1'b0;
      check("lost_vs_pause_state", 32'(game_state), 32'd0);
      check("lost_vs_pause_paused", 32'(paused), 32'd0);
      cyc(4);
      check("lost_stays_ready", 32'(game_state), 32'd0);
      key(8'h50, 1'b0);
      cyc(1);

      // ball_lost beats 'W' in READY: no launch
      key(8'h57, 1'b1);
      ball_lost = 1'b1;
      cyc(1);
      ball_lost = 1'b0;
      check("lost_vs_launch_pulse", 32'(launch), 32'd0);
      check("lost_vs_launch_state", 32'(game_state), 32'd0);
      key(8'h57, 1'b0);
      cyc(1);

      // Reset mid-move, then run to the left limit
      key(8'h41, 1'b1);
      cyc(6);
      rst = 1'b0;
      #2;
      check("midreset_x", 32'(paddle_x), 32'd280);
      check("midreset_state", 32'(game_state), 32'd0);
      rst = 1'b1;
      mx = 280; mh = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(4);
         model_move(1'b0);
         check($sformatf("leftlim_tick%0d", i), 32'(paddle_x), 32'(mx));
      end
      check("left_saturated", 32'(paddle_x), 32'd0);
      key(8'h41, 1'b0);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
